// File: rtl/alu_issue.sv
// Issue stage: decodes an RV32I instruction into ALU operands and control, then
// queues it in a two-entry skid buffer so the ALU can stall without a ready path to decode.
`timescale 1ns/1ps

package alu_pkg;
  typedef logic [31:0] data_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;
endpackage

module alu_issue
  import alu_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    flush_i,
  input  logic    in_valid_i,
  output logic    in_ready_o,
  input  logic [31:0] instr_i,
  input  data_t   pc_i,
  input  data_t   rs1_data_i,
  input  data_t   rs2_data_i,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output data_t   a_o,
  output data_t   b_o,
  output alu_op_e alu_op_o,
  output logic [4:0] rd_o,
  output logic    rd_we_o,
  output logic    branch_o,
  output logic    taken_on_zero_o,
  output logic    illegal_o
);

  typedef struct packed {
    data_t      a;
    data_t      b;
    alu_op_e    op;
    logic [4:0] rd;
    logic       rd_we;
    logic       branch;
    logic       tz;
    logic       illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [31:0] imm_i;
  data_t              imm_u;
  data_t              shamt;
  entry_t             dec_p0;
  logic               legal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign shamt  = {27'b0, instr_i[24:20]};

  // Stage p0: combinational decode of the incoming instruction
  always_comb begin
    dec_p0    = '0;
    dec_p0.op = ALU_ADD;
    legal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_p0.a = rs1_data_i;
        dec_p0.b = rs2_data_i;
        legal    = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_p0.op = ALU_ADD;
            3'b001:  dec_p0.op = ALU_SLL;
            3'b010:  dec_p0.op = ALU_SLT;
            3'b011:  dec_p0.op = ALU_SLTU;
            3'b100:  dec_p0.op = ALU_XOR;
            3'b101:  dec_p0.op = ALU_SRL;
            3'b110:  dec_p0.op = ALU_OR;
            default: dec_p0.op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_p0.op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_p0.op = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec_p0.a = rs1_data_i;
        dec_p0.b = data_t'(imm_i);
        legal    = 1'b1;
        case (funct3)
          3'b000: dec_p0.op = ALU_ADD;
          3'b010: dec_p0.op = ALU_SLT;
          3'b011: dec_p0.op = ALU_SLTU;
          3'b100: dec_p0.op = ALU_XOR;
          3'b110: dec_p0.op = ALU_OR;
          3'b111: dec_p0.op = ALU_AND;
          3'b001: begin
            dec_p0.op = ALU_SLL;
            dec_p0.b  = shamt;
            legal     = (funct7 == 7'b0000000);
          end
          default: begin
            dec_p0.b = shamt;
            if (funct7 == 7'b0000000)      dec_p0.op = ALU_SRL;
            else if (funct7 == 7'b0100000) dec_p0.op = ALU_SRA;
            else                           legal     = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        dec_p0.b = imm_u;
        legal    = 1'b1;
      end
      OPC_AUIPC: begin
        dec_p0.a = pc_i;
        dec_p0.b = imm_u;
        legal    = 1'b1;
      end
      OPC_BRANCH: begin
        dec_p0.a      = rs1_data_i;
        dec_p0.b      = rs2_data_i;
        dec_p0.branch = 1'b1;
        legal         = 1'b1;
        // Each compare reduces to an ALU result tested against zero
        case (funct3)
          3'b000: begin dec_p0.op = ALU_SUB;  dec_p0.tz = 1'b1; end
          3'b001: begin dec_p0.op = ALU_SUB;  dec_p0.tz = 1'b0; end
          3'b100: begin dec_p0.op = ALU_SLT;  dec_p0.tz = 1'b0; end
          3'b101: begin dec_p0.op = ALU_SLT;  dec_p0.tz = 1'b1; end
          3'b110: begin dec_p0.op = ALU_SLTU; dec_p0.tz = 1'b0; end
          3'b111: begin dec_p0.op = ALU_SLTU; dec_p0.tz = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (legal && !dec_p0.branch) begin
      dec_p0.rd    = instr_i[11:7];
      dec_p0.rd_we = 1'b1;
    end
    if (!legal) begin
      dec_p0         = '0;
      dec_p0.op      = ALU_ADD;
      dec_p0.illegal = 1'b1;
    end
  end

  state_e state_q, state_d;
  entry_t main_p1, skid_p1;
  logic   accept, fire;
  logic   load_main, main_from_skid, load_skid;

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign fire        = out_valid_o & out_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && fire) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        default: begin
          if (fire) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Stage p1: main entry drives the ALU, skid holds the overflow entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main) main_p1 <= main_from_skid ? skid_p1 : dec_p0;
      if (load_skid) skid_p1 <= dec_p0;
    end
  end

  assign a_o             = main_p1.a;
  assign b_o             = main_p1.b;
  assign alu_op_o        = main_p1.op;
  assign rd_o            = main_p1.rd;
  assign rd_we_o         = main_p1.rd_we;
  assign branch_o        = main_p1.branch;
  assign taken_on_zero_o = main_p1.tz;
  assign illegal_o       = main_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed test-plan steps, then random traffic checked
// against a queue-based model of the issue buffer and an independent decoder.
`timescale 1ns/1ps

module tb_alu_issue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] instr_i;
  data_t      pc_i, rs1_data_i, rs2_data_i, a_o, b_o;
  alu_op_e    alu_op_o;
  logic [4:0] rd_o;
  logic       rd_we_o, branch_o, taken_on_zero_o, illegal_o;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .a_o(a_o), .b_o(b_o), .alu_op_o(alu_op_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .branch_o(branch_o), .taken_on_zero_o(taken_on_zero_o), .illegal_o(illegal_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        tz;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t blank();
    exp_t e;
    e.a = 0; e.b = 0; e.op = ALU_ADD; e.rd = 0;
    e.we = 0; e.br = 0; e.tz = 0; e.ill = 0;
    return e;
  endfunction

  // Reference decoder, written straight from the instruction-set tables
  function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc,
                                      logic [31:0] r1, logic [31:0] r2);
    exp_t e;
    bit ok;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] simm, uimm, sh;
    e = blank();
    ok = 1'b1;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    simm = 32'($signed(ins[31:20]));
    uimm = ins & 32'hFFFF_F000;
    sh = 32'(ins[24:20]);
    case (opc)
      7'h33: begin
        e.a = r1; e.b = r2;
        case ({f7, f3})
          {7'h00, 3'd0}: e.op = ALU_ADD;
          {7'h00, 3'd1}: e.op = ALU_SLL;
          {7'h00, 3'd2}: e.op = ALU_SLT;
          {7'h00, 3'd3}: e.op = ALU_SLTU;
          {7'h00, 3'd4}: e.op = ALU_XOR;
          {7'h00, 3'd5}: e.op = ALU_SRL;
          {7'h00, 3'd6}: e.op = ALU_OR;
          {7'h00, 3'd7}: e.op = ALU_AND;
          {7'h20, 3'd0}: e.op = ALU_SUB;
          {7'h20, 3'd5}: e.op = ALU_SRA;
          default: ok = 1'b0;
        endcase
      end
      7'h13: begin
        e.a = r1; e.b = simm;
        case (f3)
          3'd0: e.op = ALU_ADD;
          3'd2: e.op = ALU_SLT;
          3'd3: e.op = ALU_SLTU;
          3'd4: e.op = ALU_XOR;
          3'd6: e.op = ALU_OR;
          3'd7: e.op = ALU_AND;
          3'd1: begin e.op = ALU_SLL; e.b = sh; ok = (f7 == 7'h00); end
          default: begin
            e.b = sh;
            if (f7 == 7'h00) e.op = ALU_SRL;
            else if (f7 == 7'h20) e.op = ALU_SRA;
            else ok = 1'b0;
          end
        endcase
      end
      7'h37: begin e.a = 0;  e.b = uimm; end
      7'h17: begin e.a = pc; e.b = uimm; end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1'b1;
        case (f3)
          3'd0: begin e.op = ALU_SUB;  e.tz = 1; end
          3'd1: begin e.op = ALU_SUB;  e.tz = 0; end
          3'd4: begin e.op = ALU_SLT;  e.tz = 0; end
          3'd5: begin e.op = ALU_SLT;  e.tz = 1; end
          3'd6: begin e.op = ALU_SLTU; e.tz = 0; end
          3'd7: begin e.op = ALU_SLTU; e.tz = 1; end
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = blank();
      e.ill = 1'b1;
    end else if (!e.br) begin
      e.rd = ins[11:7];
      e.we = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("in_ready", 32'(in_ready_o), 32'(q.size() < 2));
    check("out_valid", 32'(out_valid_o), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("a", a_o, q[0].a);
      check("b", b_o, q[0].b);
      check("op", 32'(alu_op_o), 32'(q[0].op));
      check("rd", 32'(rd_o), 32'(q[0].rd));
      check("rd_we", 32'(rd_we_o), 32'(q[0].we));
      check("branch", 32'(branch_o), 32'(q[0].br));
      check("tz", 32'(taken_on_zero_o), 32'(q[0].tz));
      check("illegal", 32'(illegal_o), 32'(q[0].ill));
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model at posedge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl);
    bit acc, fir;
    exp_t e;
    in_valid_i = v; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    out_ready_i = ordy; flush_i = fl;
    @(negedge clk);
    check_model();
    acc = v && (q.size() < 2);
    fir = (q.size() > 0) && ordy;
    e = ref_decode(ins, pc, r1, r2);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (fir) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] opcs [6];
    opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h37;
    opcs[3] = 7'h17; opcs[4] = 7'h63; opcs[5] = 7'($urandom);
    ins = $urandom;
    ins[6:0] = opcs[$urandom_range(0, 5)];
    case ($urandom_range(0, 2))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'hFFF1_0093;
    pc_i = 0; rs1_data_i = 5; rs2_data_i = 0; out_ready_i = 1'b1;

    // Reset held with valid input present
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(out_valid_o), 0);
    check("rst in_ready", 32'(in_ready_o), 1);
    check("rst op", 32'(alu_op_o), 32'(ALU_ADD));
    check("rst a", a_o, 0);
    check("rst rd", 32'(rd_o), 0);
    check("rst illegal", 32'(illegal_o), 0);
    in_valid_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("post-rst out_valid", 32'(out_valid_o), 0);

    // ADDI x1,x2,-1
    cycle(1, 32'hFFF1_0093, 32'h100, 5, 9, 1, 0);
    check("addi a", a_o, 5);
    check("addi b", b_o, 32'hFFFF_FFFF);
    check("addi op", 32'(alu_op_o), 32'(ALU_ADD));
    check("addi rd", 32'(rd_o), 1);
    check("addi we", 32'(rd_we_o), 1);
    check("addi ill", 32'(illegal_o), 0);

    // SRAI x3,x4,7 then the same with a bad funct7
    cycle(1, 32'h4072_5193, 32'h104, 32'h8000_0000, 0, 1, 0);
    check("srai b", b_o, 7);
    check("srai op", 32'(alu_op_o), 32'(ALU_SRA));
    check("srai rd", 32'(rd_o), 3);
    cycle(1, 32'h6072_5193, 32'h108, 1, 2, 1, 0);
    check("bad-srai ill", 32'(illegal_o), 1);
    check("bad-srai we", 32'(rd_we_o), 0);

    // BLTU
    cycle(1, 32'h0020_E463, 32'h10C, 1, 2, 1, 0);
    check("bltu op", 32'(alu_op_o), 32'(ALU_SLTU));
    check("bltu a", a_o, 1);
    check("bltu b", b_o, 2);
    check("bltu br", 32'(branch_o), 1);
    check("bltu tz", 32'(taken_on_zero_o), 0);
    check("bltu we", 32'(rd_we_o), 0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Backpressure: addi x1/x2/x3 with ALU stalled
    cycle(1, 32'h0010_0093, 0, 0, 0, 0, 0);
    cycle(1, 32'h0020_0113, 0, 0, 0, 0, 0);
    check("bp ready after 2", 32'(in_ready_o), 0);
    check("bp head", 32'(rd_o), 1);
    cycle(1, 32'h0030_0193, 0, 0, 0, 0, 0);
    check("bp hold head", 32'(rd_o), 1);
    cycle(1, 32'h0030_0193, 0, 0, 0, 1, 0);
    check("bp second", 32'(rd_o), 2);
    check("bp ready back", 32'(in_ready_o), 1);
    cycle(1, 32'h0030_0193, 0, 0, 0, 1, 0);
    check("bp third", 32'(rd_o), 3);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("bp drained", 32'(out_valid_o), 0);

    // Flush while full, with a valid input in the flush cycle
    cycle(1, 32'h0010_0093, 0, 0, 0, 0, 0);
    cycle(1, 32'h0020_0113, 0, 0, 0, 0, 0);
    cycle(1, 32'h0040_0213, 0, 0, 0, 0, 1);
    check("flush out_valid", 32'(out_valid_o), 0);
    check("flush in_ready", 32'(in_ready_o), 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("flush no ghost", 32'(out_valid_o), 0);

    // Flush in ONE with an acceptable input: that input is dropped
    cycle(1, 32'h0010_0093, 0, 0, 0, 0, 0);
    cycle(1, 32'h0020_0113, 0, 0, 0, 0, 1);
    check("flush1 out_valid", 32'(out_valid_o), 0);

    // Asynchronous reset mid-operation
    cycle(1, 32'h0010_0093, 0, 0, 0, 0, 0);
    cycle(1, 32'h0020_0113, 0, 0, 0, 0, 0);
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("arst out_valid", 32'(out_valid_o), 0);
    check("arst in_ready", 32'(in_ready_o), 1);
    check("arst rd", 32'(rd_o), 0);
    check("arst we", 32'(rd_we_o), 0);
    q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, rand_instr(), $urandom, $urandom, $urandom,
            ($urandom % 3) != 0, ($urandom % 30) == 0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    check("final empty", 32'(out_valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
